// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU_op encodings, issuer FSM state type and default width.
// Revision: 1.0
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_MOD_WAIT = 2'b10,
    ST_RESP     = 2'b11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_issuer_if.sv
// alu_op_issuer_if: command, ALU and response signals of the ALU_op issuer.
// Revision: 1.0
`default_nettype none

interface alu_op_issuer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [2:0]       ALU_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;
  logic             mod_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, mod_done, rsp_ready,
    output cmd_ready, ALU_op, alu_a, alu_b, alu_start, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, mod_done, rsp_ready,
    input  cmd_ready, ALU_op, alu_a, alu_b, alu_start, rsp_valid, rsp_result, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/alu_op_watchdog.sv
// alu_op_watchdog: MOD_WAIT cycle counter, flags expiry on the MAX_CYCLES-th waiting cycle.
// Revision: 1.0
`default_nettype none

module alu_op_watchdog #(
  parameter int MAX_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 c_CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MAX_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // Expiry fires in the cycle whose increment would make the count reach the limit.
  assign o_expired = i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: single-outstanding command master for the 3-bit ALU_op interface.
// Optional MOD watchdog enabled by defining MOD_TIMEOUT_EN. Revision: 1.0
`default_nettype none

module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int MOD_MAX_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_op_issuer_if.master bus
);

  state_t           r_state;
  logic             r_live;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_start;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_err;

  logic w_cmd_ready;
  logic w_accept;
  logic w_mod_expired;

  generate
    if (MOD_MAX_CYCLES < 1) begin : g_bad_cfg
      $error("alu_op_issuer: MOD_MAX_CYCLES must be at least 1");
    end
  endgenerate

  // r_live keeps cmd_ready low until the first clock edge after reset release.
  assign w_cmd_ready = r_live && (r_state == ST_IDLE);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

`ifdef MOD_TIMEOUT_EN
  logic w_wd_clr;
  logic w_wd_en;

  assign w_wd_clr = w_accept && (bus.cmd_op == OP_MOD);
  assign w_wd_en  = (r_state == ST_MOD_WAIT) && !bus.mod_done;

  alu_op_watchdog #(
    .MAX_CYCLES (MOD_MAX_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_mod_expired)
  );
`else
  assign w_mod_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_live       <= 1'b0;
      r_alu_op     <= OP_AND;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_start  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_alu_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_op <= bus.cmd_op;
            r_alu_a  <= bus.cmd_a;
            r_alu_b  <= bus.cmd_b;
            if (bus.cmd_op == OP_MOD) begin
              r_alu_start <= 1'b1;
              r_state     <= ST_MOD_WAIT;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_err    <= 1'b0;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_MOD_WAIT: begin
          // A completion arriving with the limit takes priority over the timeout.
          if (bus.mod_done) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else if (w_mod_expired) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.ALU_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_start  = r_alu_start;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_err    = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: table-driven and scripted checks of alu_op_issuer with a response scoreboard.
// Revision: 1.0
`default_nettype none

module tb_alu_op_issuer;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] mod_val;
  int          n_vec;
  int          n_err;
  exp_t        sb[$];
  vec_t        vecs[9];

  alu_op_issuer_if #(.WIDTH(32)) bus ();

  alu_op_issuer #(
    .WIDTH          (32),
    .MOD_MAX_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101:  return a + b;
      3'b110:  return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.alu_result = (bus.ALU_op == 3'b111) ? mod_val : alu_ref(bus.ALU_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic err);
    int   t;
    exp_t e;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept_timeout: cmd_ready stuck at 0, want 1");
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    e.res = res;
    e.err = err;
    sb.push_back(e);
    chk("alu_op", {29'd0, bus.ALU_op}, {29'd0, op});
    chk("alu_a", bus.alu_a, a);
    chk("alu_b", bus.alu_b, b);
  endtask

  task automatic wait_rsp(input int hold, input int exp_lat);
    int          t;
    logic [31:0] held;
    exp_t        e;
    t = 0;
    while (!bus.rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rsp_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout: rsp_valid stuck at 0, want 1");
      return;
    end
    if (exp_lat >= 0) chk("rsp_latency", 32'(t), 32'(exp_lat));
    held = bus.rsp_result;
    for (int h = 0; h < hold; h++) begin
      chk("cmd_ready_in_resp", {31'd0, bus.cmd_ready}, 32'd0);
      @(negedge clk);
      chk("rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rsp_result_stable", bus.rsp_result, held);
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_rsp: got 0x%08h, want no response", bus.rsp_result);
    end else begin
      e = sb.pop_front();
      chk("rsp_result", bus.rsp_result, e.res);
      chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int pulses;
    n_vec = 0;
    n_err = 0;
    mod_val       = 32'd0;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.mod_done  = 1'b0;
    bus.rsp_ready = 1'b0;

    vecs[0] = '{3'b101, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{3'b001, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FFF0};
    vecs[2] = '{3'b010, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00};
    vecs[3] = '{3'b100, 32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[4] = '{3'b100, 32'd5,          32'hFFFF_FFFD,  32'd0};
    vecs[5] = '{3'b110, 32'd10,         32'd3,          32'd7};
    vecs[6] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[7] = '{3'b000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0};
    vecs[8] = '{3'b011, 32'h0000_F0F0,  32'h0000_0FF0,  32'hFFFF_000F};

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b101;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_alu_op", {29'd0, bus.ALU_op}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    bus.cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b0);
      wait_rsp(i % 3, 1);
    end

    issue(3'b110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    wait_rsp(4, 1);

    mod_val = 32'd2;
    issue(3'b111, 32'd17, 32'd5, 32'd2, 1'b0);
    pulses = 0;
    for (int c = 1; c <= 4; c++) begin
      pulses += int'(bus.alu_start);
      chk("mod_alu_op_stable", {29'd0, bus.ALU_op}, 32'd7);
      chk("mod_alu_a_stable", bus.alu_a, 32'd17);
      if (c < 4) @(negedge clk);
    end
    bus.mod_done = 1'b1;
    @(negedge clk);
    bus.mod_done = 1'b0;
    pulses += int'(bus.alu_start);
    chk("mod_start_pulses", 32'(pulses), 32'd1);
    wait_rsp(0, 0);

    mod_val = 32'd1;
    issue(3'b111, 32'd9, 32'd4, 32'd1, 1'b0);
    chk("mod_start_first_cycle", {31'd0, bus.alu_start}, 32'd1);
    bus.mod_done = 1'b1;
    @(negedge clk);
    bus.mod_done = 1'b0;
    wait_rsp(0, 0);

    // Held cmd_valid: second command must wait for the first response handshake.
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 32'h0000_F0F0;
    bus.cmd_b     = 32'h0000_0FF0;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    sb.push_back('{32'h0000_00F0, 1'b0});
    bus.cmd_op = 3'b011;
    chk("b2b_first_op", {29'd0, bus.ALU_op}, 32'd0);
    wait_rsp(2, 1);
    chk("b2b_idle_op_held", {29'd0, bus.ALU_op}, 32'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    sb.push_back('{32'hFFFF_000F, 1'b0});
    chk("b2b_second_op", {29'd0, bus.ALU_op}, 32'd3);
    wait_rsp(0, 1);

    mod_val = 32'd2;
    issue(3'b111, 32'd17, 32'd5, 32'd2, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_alu_op", {29'd0, bus.ALU_op}, 32'd0);
    chk("midrst_alu_b", bus.alu_b, 32'd0);
    chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mod_val = 32'd99;
    bus.mod_done = 1'b1;
    @(negedge clk);
    bus.mod_done = 1'b0;
    chk("stray_mod_done_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    chk("stray_mod_done_ready", {31'd0, bus.cmd_ready}, 32'd1);
    issue(3'b101, 32'd1, 32'd1, 32'd2, 1'b0);
    wait_rsp(0, 1);

`ifdef MOD_TIMEOUT_EN
    issue(3'b111, 32'd20, 32'd6, 32'd0, 1'b1);
    wait_rsp(0, 8);
    mod_val = 32'h33;
    issue(3'b111, 32'd51, 32'd6, 32'h33, 1'b0);
    repeat (7) @(negedge clk);
    bus.mod_done = 1'b1;
    @(negedge clk);
    bus.mod_done = 1'b0;
    wait_rsp(0, 0);
`else
    mod_val = 32'h44;
    issue(3'b111, 32'd68, 32'd6, 32'h44, 1'b0);
    repeat (20) @(negedge clk);
    chk("mod_no_timeout_valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.mod_done = 1'b1;
    @(negedge clk);
    bus.mod_done = 1'b0;
    wait_rsp(0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Command-side master for the 3-bit ALU_op interface.
- Accepts one ALU command at a time over a valid/ready handshake, encodes it onto ALU_op and registered operands, and captures the result.
- Single-cycle ops complete after one EXEC cycle. MOD is sequenced as a multi-cycle operation: start pulse, then wait for mod_done.
- Sits between the instruction/test front-end and the ALU datapath.

Parameters:
WIDTH, 32, operand/result width
MOD_MAX_CYCLES, 64, watchdog limit for MOD (used only with MOD_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  issuer can accept command
cmd_op  input  3  operation code (ALU_op encoding)
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
ALU_op  output  3  encoded op driven to ALU
alu_a  output  WIDTH  registered operand A
alu_b  output  WIDTH  registered operand B
alu_start  output  1  one-cycle MOD start pulse
alu_result  input  WIDTH  ALU result (combinational for non-MOD, valid with mod_done for MOD)
mod_done  input  1  MOD unit finished
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  captured result
rsp_err  output  1  MOD timed out (0 when feature disabled)

Behaviour:
- Encoding (ALU_op): 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD.
- Reset (async, reset_n=0): state IDLE; ALU_op=000; alu_a=alu_b=0; alu_start=0; rsp_valid=0; rsp_result=0; rsp_err=0; cmd_ready=0 while reset_n low, 1 in first IDLE cycle after release.
- FSM: IDLE, EXEC, MOD_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch cmd_op into ALU_op, cmd_a/cmd_b into alu_a/alu_b.
  - Go to EXEC if op≠111. Go to MOD_WAIT if op=111, with alu_start=1 in the first MOD_WAIT cycle only.
- EXEC:
  - One cycle; capture alu_result into rsp_result at the end of this cycle; go to RESP.
  - Latency: handshake at edge N, rsp_valid=1 after edge N+2.
- MOD_WAIT:
  - ALU_op, alu_a, alu_b held stable.
  - On mod_done=1: capture alu_result and go to RESP.
  - mod_done in the same cycle as alu_start is legal and accepted.
  - mod_done seen in any state other than MOD_WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_result and rsp_err stable until rsp_valid&rsp_ready, then go to IDLE.
  - cmd_ready=0 throughout; no command overlap, so throughput is at most one command per 3 cycles.
- ALU_op, alu_a and alu_b keep their last values in IDLE (no toggling); they change only on an accepted handshake.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- reset_n asserted mid-MOD: immediate return to reset values; any in-flight MOD result is discarded.
- All outputs are registered except cmd_ready, which is decoded from state.

Optional Feature:
MOD_TIMEOUT_EN
- Defined:
  - A cycle counter (width clog2(MOD_MAX_CYCLES+1)) clears on MOD_WAIT entry and increments each MOD_WAIT cycle without mod_done.
  - On reaching MOD_MAX_CYCLES: go to RESP with rsp_err=1 and rsp_result=0.
  - rsp_err clears on the response handshake.
  - mod_done in the same cycle as the limit wins: normal result, rsp_err=0.
- Not defined: no counter; MOD_WAIT waits indefinitely; rsp_err tied 0.

Decomposition:
- Shared package alu_pkg:
  - localparams for the eight ALU_op codes (OP_AND..OP_MOD);
  - FSM state encoding (2-bit);
  - default WIDTH.
- One natural sub-module: alu_op_watchdog (counter + expiry flag), instantiated only under MOD_TIMEOUT_EN.
- The rest is a single FSM module.

Test Plan:
- Reset release, then ADD: cmd_op=101, a=5, b=7 -> ALU_op=101 after edge N+1, rsp_valid after edge N+2, rsp_result=12, rsp_err=0.
- SUB with backpressure: op=110, a=3, b=5, rsp_ready held 0 for 4 cycles -> rsp_result=0xFFFFFFFE held stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
- MOD: op=111, a=17, b=5, mod_done after 4 cycles with alu_result=2 -> exactly one alu_start pulse, ALU_op=111 stable, rsp_result=2.
- Back-to-back commands: cmd_valid held with AND then NOR (0xF0F0, 0x0FF0) -> second accepted only after first response handshake; results 0x00F0 and 0xFFFF000F.
- reset_n low during MOD_WAIT cycle 2 -> all outputs at reset values asynchronously; a later mod_done is ignored; next ADD 1+1=2 completes normally.
- MOD_TIMEOUT_EN with MOD_MAX_CYCLES=8, mod_done never asserted -> rsp_valid after 8 MOD_WAIT cycles, rsp_err=1, rsp_result=0; repeated with mod_done at cycle 8 -> rsp_err=0.
